chess_countdown: RTL and testbench
==================================

# chess_countdown

Two-player chess clock countdown engine. It holds both players' remaining time, decrements the running player once per second, and handles move-hand-off, pause and time-expiry. Its `counted_time` output feeds the display data mux, which selects between the preset view and this counted view. It uses the same packed format: per player, minutes[7:0] and seconds[5:0].

## Interface
- `TICK_DIV`, default 100000000: clock cycles per one-second tick (Nexys 4 100 MHz); benches override it with small values.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: synchronous preset of both players to `time_in`:00; level-sampled every cycle.
- `time_in` in 8: preset minutes, 0..255, taken as-is.
- `press_a` in 1: one-cycle pulse (debounced upstream); player A ends move.
- `press_b` in 1: one-cycle pulse; player B ends move.
- `pause` in 1: one-cycle pulse; toggles pause.
- `counted_time` out 32: {4'b0, minA[7:0], secA[5:0], minB[7:0], secB[5:0]}.
- `run_a`, `run_b` out 1 each: high in RUN_A / RUN_B respectively.
- `paused` out 1: high in PAUSE_A or PAUSE_B.
- `flag_a`, `flag_b` out 1 each: high in EXP_A / EXP_B respectively.

## Operation
- States: IDLE, RUN_A, RUN_B, PAUSE_A, PAUSE_B, EXP_A, EXP_B.
- Reset: state IDLE, `counted_time` = 0, all flag/status outputs 0, prescaler 0.
- `load` has top priority in every state:
  - both fields become `time_in`:00;
  - state goes to IDLE;
  - prescaler is cleared;
  - presses and pause are ignored that cycle.
- IDLE:
  - `press_a` goes to RUN_B; `press_b` goes to RUN_A; both at once are ignored; `pause` is ignored.
  - If the player about to start has 0:00, go directly to EXP_x instead.
- RUN_A:
  - `pause` goes to PAUSE_A and has priority over a press.
  - `press_a` goes to RUN_B, or to EXP_B if B is 0:00.
  - `press_b` is ignored.
  - RUN_B is symmetric.
- PAUSE_x: `pause` returns to RUN_x; presses are ignored; prescaler and times are held.
- EXP_x: absorbing; only `load` or reset leave it; times are frozen.
- Prescaler:
  - counts 0..TICK_DIV-1 only in RUN states;
  - a tick occurs in the cycle it equals TICK_DIV-1, then it wraps to 0;
  - cleared on a player switch, so each turn starts a fresh second.
- Decrement on tick, active player only:
  - sec>0: sec-1;
  - sec==0: sec=59, min-1.
  - Seconds are always 0..59. No underflow, because 0:00 exits RUN.
- A tick that yields 0:00 moves RUN_x to EXP_x.
- A tick and a press in the same cycle: the running player decrements first, then the switch happens. If the decrement reaches 0:00, expiry wins and the press is ignored.
- A tick and `pause` in the same cycle: the decrement happens, then the block pauses.

## Timing
- All outputs are registered and update on the rising edge after the qualifying input or tick cycle.
- `load` to `counted_time` latency: 1 cycle.
- Press to `run_a`/`run_b` change: 1 cycle.
- First decrement: TICK_DIV cycles after entering RUN; subsequent decrements every TICK_DIV cycles.
- `flag_x` rises in the same cycle `counted_time` first shows 0:00 for player x.
- `rst_n` low immediately (asynchronously) forces the reset values, including mid-run; operation resumes on the first edge after release.
- Inputs are assumed synchronous to `clk`.

## Test plan
(TICK_DIV=4 throughout.)
1. Reset, then `load` with `time_in`=5 → `counted_time`=0x00500140, state IDLE, all status outputs 0, with no decrement over 50 cycles.
2. After scenario 1, pulse `press_b` → `run_a`=1. Fourth cycle after the press edge: A shows 4:59, `counted_time`=0x004EC140. B stays 0x140 throughout.
3. Run A, pulse `pause` → `paused`=1, value frozen for 40 cycles. Pulse `pause` again → `run_a`=1, next decrement occurs after the remaining prescaler count.
4. `load` `time_in`=1, start A, run 60 ticks → A=0:00, `flag_a`=1, `run_a`=0. Later presses and pause produce no change; B stays 0x040. Then `load` → IDLE, flags cleared.
5. `press_a` in the exact tick cycle during RUN_A → A decrements once, then `run_b`=1, and B's first decrement comes 4 cycles later.
6. Drop `rst_n` asynchronously mid-RUN → `counted_time`=0 and all status outputs 0 before the next edge. After release, `press_b` with A=0:00 → `flag_a`=1 immediately.

Source files
------------

// File: rtl/chess_countdown_if.sv
// Control inputs and display/status outputs of the chess clock countdown engine.
interface chess_countdown_if;
    logic        load;
    logic [7:0]  time_in;
    logic        press_a;
    logic        press_b;
    logic        pause;
    logic [31:0] counted_time;
    logic        run_a;
    logic        run_b;
    logic        paused;
    logic        flag_a;
    logic        flag_b;

    modport master (
        output load, time_in, press_a, press_b, pause,
        input  counted_time, run_a, run_b, paused, flag_a, flag_b
    );

    modport slave (
        input  load, time_in, press_a, press_b, pause,
        output counted_time, run_a, run_b, paused, flag_a, flag_b
    );
endinterface

// File: rtl/chess_countdown.sv
// Two-player chess clock: per-player min:sec countdown with move hand-off,
// pause and time-expiry. Times are kept as packed {min[7:0], sec[5:0]}.
module chess_countdown #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input logic             clk,
    input logic             rst_n,
    chess_countdown_if.slave bus
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0] ZERO_TIME = 14'd0;

    typedef enum logic [2:0] {
        IDLE, RUN_A, RUN_B, PAUSE_A, PAUSE_B, EXP_A, EXP_B
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [13:0]   time_a, time_a_nx;
    logic [13:0]   time_b, time_b_nx;
    logic          tick;
    logic          run_a_q, run_b_q, paused_q, flag_a_q, flag_b_q;

    // One-second decrement; callers guarantee the time is never 0:00 here.
    function automatic logic [13:0] dec_time(input logic [13:0] t);
        if (t[5:0] == 6'd0)
            return {t[13:6] - 8'd1, 6'd59};
        else
            return {t[13:6], t[5:0] - 6'd1};
    endfunction

    always_comb begin
        state_nx  = state;
        presc_nx  = presc;
        time_a_nx = time_a;
        time_b_nx = time_b;
        tick      = 1'b0;
        if (bus.load) begin
            time_a_nx = {bus.time_in, 6'd0};
            time_b_nx = {bus.time_in, 6'd0};
            presc_nx  = {PW{1'b0}};
            state_nx  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    presc_nx = {PW{1'b0}};
                    if (bus.press_a && !bus.press_b)
                        state_nx = (time_b == ZERO_TIME) ? EXP_B : RUN_B;
                    else if (bus.press_b && !bus.press_a)
                        state_nx = (time_a == ZERO_TIME) ? EXP_A : RUN_A;
                end
                RUN_A: begin
                    tick     = (presc == TICK_LAST);
                    presc_nx = tick ? {PW{1'b0}} : presc + PW'(1);
                    if (tick)
                        time_a_nx = dec_time(time_a);
                    // Expiry beats pause, pause beats the hand-off.
                    if (tick && time_a_nx == ZERO_TIME)
                        state_nx = EXP_A;
                    else if (bus.pause)
                        state_nx = PAUSE_A;
                    else if (bus.press_a) begin
                        state_nx = (time_b == ZERO_TIME) ? EXP_B : RUN_B;
                        presc_nx = {PW{1'b0}};
                    end
                end
                RUN_B: begin
                    tick     = (presc == TICK_LAST);
                    presc_nx = tick ? {PW{1'b0}} : presc + PW'(1);
                    if (tick)
                        time_b_nx = dec_time(time_b);
                    if (tick && time_b_nx == ZERO_TIME)
                        state_nx = EXP_B;
                    else if (bus.pause)
                        state_nx = PAUSE_B;
                    else if (bus.press_b) begin
                        state_nx = (time_a == ZERO_TIME) ? EXP_A : RUN_A;
                        presc_nx = {PW{1'b0}};
                    end
                end
                PAUSE_A: if (bus.pause) state_nx = RUN_A;
                PAUSE_B: if (bus.pause) state_nx = RUN_B;
                EXP_A, EXP_B: state_nx = state;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Status flags are registered from the next state so they align with counted_time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            presc    <= {PW{1'b0}};
            time_a   <= ZERO_TIME;
            time_b   <= ZERO_TIME;
            run_a_q  <= 1'b0;
            run_b_q  <= 1'b0;
            paused_q <= 1'b0;
            flag_a_q <= 1'b0;
            flag_b_q <= 1'b0;
        end else begin
            state    <= state_nx;
            presc    <= presc_nx;
            time_a   <= time_a_nx;
            time_b   <= time_b_nx;
            run_a_q  <= (state_nx == RUN_A);
            run_b_q  <= (state_nx == RUN_B);
            paused_q <= (state_nx == PAUSE_A) || (state_nx == PAUSE_B);
            flag_a_q <= (state_nx == EXP_A);
            flag_b_q <= (state_nx == EXP_B);
        end
    end

    assign bus.counted_time = {4'b0, time_a, time_b};
    assign bus.run_a        = run_a_q;
    assign bus.run_b        = run_b_q;
    assign bus.paused       = paused_q;
    assign bus.flag_a       = flag_a_q;
    assign bus.flag_b       = flag_b_q;
endmodule

// File: tb/tb_chess_countdown.sv
// Bench for chess_countdown: directed scenarios plus random pulses, checked
// against a seconds-based reference model of the two clocks.
module tb_chess_countdown;
    localparam int TD = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Reference model: remaining seconds per player (index 1=A, 2=B),
    // whose turn it is (0 none), paused, who lost on time (0 none),
    // and cycles elapsed in the current second.
    int m_t[3];
    int m_turn;
    bit m_hold;
    int m_out;
    int m_phase;

    chess_countdown_if bus ();

    chess_countdown #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int a, input int b);
        logic [7:0] ma, mb;
        logic [5:0] sa, sb;
        ma = 8'(a / 60);
        sa = 6'(a % 60);
        mb = 8'(b / 60);
        sb = 6'(b % 60);
        return {4'b0, ma, sa, mb, sb};
    endfunction

    function automatic logic [31:0] exp_status();
        logic [4:0] s;
        s = {m_turn == 1 && !m_hold, m_turn == 2 && !m_hold, m_turn != 0 && m_hold,
             m_out == 1, m_out == 2};
        return 32'(s);
    endfunction

    function automatic logic [31:0] obs_status();
        logic [4:0] s;
        s = {bus.run_a, bus.run_b, bus.paused, bus.flag_a, bus.flag_b};
        return 32'(s);
    endfunction

    task automatic model_reset();
        m_t[1] = 0; m_t[2] = 0;
        m_turn = 0; m_hold = 0; m_out = 0; m_phase = 0;
    endtask

    // Hand the move to player p, or flag p if p has no time left.
    task automatic model_start(input int p);
        m_phase = 0;
        if (m_t[p] == 0) begin
            m_out  = p;
            m_turn = 0;
        end else begin
            m_turn = p;
        end
    endtask

    task automatic model_step(input bit la, input int ti, input bit pa, input bit pb, input bit pz);
        bit tick;
        if (la) begin
            model_reset();
            m_t[1] = ti * 60;
            m_t[2] = ti * 60;
        end else if (m_out != 0) begin
            // flagged: frozen
        end else if (m_turn == 0) begin
            if (pa != pb) model_start(pa ? 2 : 1);
        end else if (m_hold) begin
            if (pz) m_hold = 0;
        end else begin
            tick    = (m_phase == TD - 1);
            m_phase = tick ? 0 : m_phase + 1;
            if (tick) m_t[m_turn] = m_t[m_turn] - 1;
            if (tick && m_t[m_turn] == 0) begin
                m_out  = m_turn;
                m_turn = 0;
            end else if (pz) begin
                m_hold = 1;
            end else if ((m_turn == 1 && pa) || (m_turn == 2 && pb)) begin
                model_start(3 - m_turn);
            end
        end
    endtask

    task automatic step(input bit la, input logic [7:0] ti, input bit pa, input bit pb, input bit pz);
        bus.load    = la;
        bus.time_in = ti;
        bus.press_a = pa;
        bus.press_b = pb;
        bus.pause   = pz;
        @(posedge clk);
        model_step(la, int'(ti), pa, pb, pz);
        #1;
        check("counted", bus.counted_time, pack(m_t[1], m_t[2]));
        check("status", obs_status(), exp_status());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n       = 1'b0;
        bus.load    = 1'b0;
        bus.time_in = 8'd0;
        bus.press_a = 1'b0;
        bus.press_b = 1'b0;
        bus.pause   = 1'b0;
        #12;
        check("rst_counted", bus.counted_time, 32'h0);
        check("rst_status", obs_status(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preset and idle: no decrement
        step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        idle(50);
        check("s1_value", bus.counted_time, 32'h00500140);
        check("s1_status", obs_status(), 32'h0);

        // Start A; first decrement four edges after the press
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        check("s2_run_a", 32'(bus.run_a), 32'd1);
        idle(4);
        check("s2_first_dec", bus.counted_time, 32'h004EC140);

        // Pause and resume
        idle(2);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        check("s3_paused", 32'(bus.paused), 32'd1);
        idle(40);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        idle(10);

        // Run A down to expiry
        step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        idle(60 * TD);
        check("s4_flag_a", obs_status(), 32'b00010);
        check("s4_value", bus.counted_time, 32'h00000040);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("s4_frozen", bus.counted_time, 32'h00000040);
        step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        check("s4_reload", obs_status(), 32'h0);

        // Press in the exact tick cycle of A's turn
        step(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10 && m_phase != TD - 1; i++) idle(1);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        check("s5_a_once", bus.counted_time, pack(119, 120));
        check("s5_run_b", obs_status(), 32'b01000);
        idle(TD);
        check("s5_b_first", bus.counted_time, pack(119, 119));

        // Asynchronous reset mid-run
        step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        idle(5);
        #3 rst_n = 1'b0;
        #1;
        check("s6_rst_counted", bus.counted_time, 32'h0);
        check("s6_rst_status", obs_status(), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        check("s6_flag_a", obs_status(), 32'b00010);

        // Random pulses against the model
        for (int i = 0; i < 4000; i++) begin
            bit la, pa, pb, pz;
            logic [7:0] ti;
            la = ($urandom_range(0, 299) == 0);
            ti = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 2));
            pa = ($urandom_range(0, 11) == 0);
            pb = ($urandom_range(0, 11) == 0);
            pz = ($urandom_range(0, 15) == 0);
            step(la, ti, pa, pb, pz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
